// File: rtl/div_pkg.sv
// Shared divider constants: datapath widths, start/ready levels and FSM states.
package div_pkg;

    localparam int unsigned REGBUS       = 32;
    localparam int unsigned DOUBLEREGBUS = 64;

    localparam logic DIVSTART          = 1'b1;
    localparam logic DIVSTOP           = 1'b0;
    localparam logic DIVRESULTREADY    = 1'b1;
    localparam logic DIVRESULTNOTREADY = 1'b0;

    typedef enum logic [1:0] {
        DIVFREE   = 2'b00,
        DIVBYZERO = 2'b01,
        DIVON     = 2'b10,
        DIVEND    = 2'b11
    } div_state_e;

    // Magnitude of an operand; only signed operations with bit 31 set are negated.
    function automatic logic [REGBUS-1:0] div_abs(input logic [REGBUS-1:0] v,
                                                  input logic              is_signed);
        return (is_signed && v[REGBUS-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div.sv
// Iterative 32-bit restoring divider for DIV/DIVU; returns {remainder, quotient}.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [REGBUS-1:0]       opdata1_i,
    input  logic [REGBUS-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DOUBLEREGBUS-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [DOUBLEREGBUS-1:0] pair_q, pair_d;      // {rem, quo}
    logic [REGBUS-1:0]       divisor_q, divisor_d;
    logic                    sign1_q, sign1_d;
    logic                    sign2_q, sign2_d;
    logic                    signed_q, signed_d;
    logic [DOUBLEREGBUS-1:0] result_q, result_d;

    logic [REGBUS:0]         trial;
    logic [REGBUS-1:0]       rem_fix;
    logic [REGBUS-1:0]       quo_fix;

    // Step subtractor and signed fix-up of the finished pair.
    always_comb begin
        trial   = pair_q[DOUBLEREGBUS-1:REGBUS-1] - {1'b0, divisor_q};
        rem_fix = (signed_q && sign1_q) ? -pair_q[DOUBLEREGBUS-1:REGBUS]
                                        :  pair_q[DOUBLEREGBUS-1:REGBUS];
        quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -pair_q[REGBUS-1:0]
                                                    :  pair_q[REGBUS-1:0];
    end

    // Next-state and datapath update; result_q is nonzero only while in END.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        signed_d  = signed_q;
        result_d  = result_q;
        unique case (state_q)
            DIVFREE: begin
                if (start_i == DIVSTART && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIVBYZERO;
                    end else begin
                        state_d   = DIVON;
                        cnt_d     = '0;
                        pair_d    = {{REGBUS{1'b0}}, div_abs(opdata1_i, signed_div_i)};
                        divisor_d = div_abs(opdata2_i, signed_div_i);
                        sign1_d   = opdata1_i[REGBUS-1];
                        sign2_d   = opdata2_i[REGBUS-1];
                        signed_d  = signed_div_i;
                    end
                end
            end
            DIVBYZERO: begin
                state_d  = annul_i ? DIVFREE : DIVEND;
                result_d = '0;
            end
            DIVON: begin
                if (annul_i) begin
                    state_d = DIVFREE;
                end else if (cnt_q < 6'd32) begin
                    // Whole-pair left shift; on a non-negative trial the upper half takes the difference.
                    if (!trial[REGBUS]) begin
                        pair_d = {trial[REGBUS-1:0], pair_q[REGBUS-2:0], 1'b1};
                    end else begin
                        pair_d = {pair_q[DOUBLEREGBUS-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DIVEND;
                    result_d = {rem_fix, quo_fix};
                end
            end
            DIVEND: begin
                if (start_i == DIVSTOP) begin
                    state_d  = DIVFREE;
                    result_d = '0;
                end
            end
            default: state_d = DIVFREE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIVFREE;
            cnt_q     <= '0;
            pair_q    <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            signed_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pair_q    <= pair_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            signed_q  <= signed_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DIVEND) ? DIVRESULTREADY : DIVRESULTNOTREADY;

endmodule

// File: doc/div.md
# div

Iterative 32-bit integer divider serving the EX stage's DIV/DIVU instructions: a start/ready responder that latches two operands, runs a 32-step restoring shift-subtract loop, and returns `{remainder, quotient}` for writing into HI/LO. EX drives `start_i` and holds its stall request until `ready_o` rises. The block sits beside EX and is clocked with the pipeline.

## Interface
Parameters: none. Widths come from the shared `macro.v` constants (`REGBUS` = 32 bits, `DOUBLEREGBUS` = 64 bits).

Ports:
- `clk`  in  1  pipeline clock; rising-edge active.
- `rst`  in  1  asynchronous, active-high reset (`RSTENABLE`).
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU (unsigned).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  `DIVSTART`/`DIVSTOP`; held by EX until the result is consumed.
- `annul_i`  in  1  abort the current division (flush or exception).
- `result_o`  out  64  `[63:32]` remainder → HI, `[31:0]` quotient → LO.
- `ready_o`  out  1  `DIVRESULTREADY` while `result_o` is valid.

## Operation
- State machine with four states:
  - FREE → on `start_i && !annul_i`, go to BYZERO if `opdata2_i == 0`, otherwise to ON. On entry to ON, latch `|opdata1|`, `|opdata2|`, both sign bits and `signed_div_i`, and clear `cnt`.
  - ON → `annul_i` returns to FREE with no result. While `cnt < 32`, perform one step and increment `cnt`. When `cnt == 32`, go to END.
  - BYZERO → go to END with result 0. `annul_i` returns to FREE.
  - END → `ready_o = 1`. Stay here while `start_i` is held. Return to FREE on `start_i == DIVSTOP`. `annul_i` is ignored.
- Absolute values are taken only when the operation is signed and the operand's bit 31 is set (two's complement). The magnitude of `0x80000000` is `0x80000000` read as unsigned.
- One step: `trial` = 33-bit `{rem[31:0], quo[31]} - {1'b0, divisor}`.
  - If `trial[32] == 0`: `rem = trial[31:0]` and shift `1` into the quotient LSB.
  - Otherwise: `rem = {rem[30:0], quo[31]}` and shift in `0`.
- Fix-up on the transition into END, signed operations only:
  - negate the quotient if the dividend and divisor signs differ;
  - negate the remainder if the dividend is negative.
  - Result is registered into `result_o`.
- Operand changes after the start cycle are ignored.
- Outputs outside END: `result_o = 0`, `ready_o = 0`.
- Reset value of every output is 0, and the state is FREE.

## Timing
- The edge that samples `start_i` in FREE is E0.
- Nonzero divisor: steps occur on E1..E32, END is entered on E33, and `ready_o` is high from E33 onward. Latency is 33 cycles.
- Divisor zero: BYZERO is entered on E0, END on E1, and `ready_o` is high from E1.
- `ready_o` and `result_o` stay stable for as long as END is held.
- After `start_i` drops, the block is in FREE at the next edge, and a new start can be sampled on the edge after that.
- `annul_i` takes effect on the same edge it is sampled. `ready_o` never asserts for an annulled operation.
- `rst` forces FREE and zero outputs immediately, without waiting for a clock edge, including mid-ON.

## Structure
- The constants `DIVFREE`, `DIVBYZERO`, `DIVON`, `DIVEND` (2-bit state encodings), `DIVSTART`/`DIVSTOP` and `DIVRESULTREADY`/`DIVRESULTNOTREADY` belong in shared `macro.v`.
- Single module, no sub-module. The step subtractor and negation logic are inline combinational logic.
- Registers: state, a 6-bit `cnt`, the 64-bit `{rem, quo}` shift pair, the latched divisor, the sign/mode flags, and `result_o`.

## Test plan
- Unsigned 100/7 → `ready_o` rises 33 edges after start; `result_o = 0x00000002_0000000E`; ready is held until `start_i` drops.
- Signed −7/2 (`0xFFFFFFF9`, `0x00000002`) → `result_o = 0xFFFFFFFF_FFFFFFFD`. Signed 7/−2 → `0x00000001_FFFFFFFD`.
- Signed `0x80000000`/`0xFFFFFFFF` → `result_o = 0x00000000_80000000`. Unsigned `0xFFFFFFFF`/1 → `0x00000000_FFFFFFFF`.
- Divide by zero, 5/0 → `ready_o` high from E1, `result_o = 0`.
- `annul_i` at `cnt == 10` → FREE at the next edge and `ready_o` stays 0. A new start of 9/3 then yields `0x00000000_00000003`.
- `rst` pulsed mid-ON at `cnt == 20`, between clock edges → `ready_o = 0` and `result_o = 0` immediately. After release, a restarted 100/7 completes correctly.
